// File: rtl/display_scan_ctrl_pkg.sv
// Shared types and constants for the four-digit 7-segment scan controller.
package display_scan_ctrl_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned NIB_W      = 4;
    localparam int unsigned DATA_W     = NUM_DIGITS * NIB_W;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned IDX_W      = 2;
    localparam int unsigned GCNT_W     = 4;

    localparam logic [SEG_W-1:0] BLANK_SEG = 7'h7F;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_SCAN  = 2'd1,
        ST_GUARD = 2'd2
    } scan_state_e;

    // One displayable value: four nibbles plus their decimal points.
    typedef struct packed {
        logic [NUM_DIGITS-1:0]            dp;
        logic [NUM_DIGITS-1:0][NIB_W-1:0] nib;
    } digit_buf_t;

    // Active-low {g..a} glyphs, entry 15 first: F E d C b A 9 8 7 6 5 4 3 2 1 0.
    localparam logic [15:0][SEG_W-1:0] GLYPH_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/display_scan_ctrl_seg7_decoder.sv
// Nibble to active-low 7-segment glyph, with forced blank.
module seg7_decoder
    import display_scan_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] nibble_i,
    input  logic             blank_i,
    output logic [SEG_W-1:0] seg_o
);

    assign seg_o = blank_i ? BLANK_SEG : GLYPH_TABLE[nibble_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// Four-digit multiplexed display scanner: guard dead-time between digits,
// double-buffered value load committed at frame start, leading-zero blanking.
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int unsigned GUARD_CYC = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Reset,
    input  logic                  i_Tick,
    input  logic                  i_En,
    input  logic                  i_Load,
    input  logic [DATA_W-1:0]     i_Data,
    input  logic [NUM_DIGITS-1:0] i_Dp,
    input  logic                  i_Lz,
    output logic [NUM_DIGITS-1:0] o_Anodo,
    output logic [SEG_W-1:0]      o_Seg,
    output logic                  o_Dp,
    output logic                  o_Pend,
    output logic                  o_Frame
);

    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [GCNT_W-1:0]     gcnt_q, gcnt_d;
    digit_buf_t            disp_q, disp_d;
    digit_buf_t            pend_q, pend_d;
    logic                  pend_vld_q, pend_vld_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic                  frame_arm_q, frame_arm_d;
    logic                  frame_q, frame_d;

    logic                  commit_c;
    logic                  lz_run_c;
    logic [NUM_DIGITS-1:0] lz_blank_c;
    logic [SEG_W-1:0]      dec_seg_c;

    // Scan sequencing; commit_c marks the clock that (re)enters digit 0.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        gcnt_d   = gcnt_q;
        commit_c = 1'b0;
        if (!i_En) begin
            state_d = ST_OFF;
            idx_d   = '0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    if (i_Tick) begin
                        state_d  = ST_SCAN;
                        idx_d    = '0;
                        commit_c = 1'b1;
                    end
                end
                ST_SCAN: begin
                    if (i_Tick) begin
                        state_d = ST_GUARD;
                        gcnt_d  = '0;
                    end
                end
                ST_GUARD: begin
                    if (gcnt_q == GCNT_W'(GUARD_CYC - 1)) begin
                        state_d  = ST_SCAN;
                        idx_d    = idx_q + IDX_W'(1);
                        commit_c = (idx_q == IDX_W'(NUM_DIGITS - 1));
                    end else begin
                        gcnt_d = gcnt_q + GCNT_W'(1);
                    end
                end
                default: state_d = ST_OFF;
            endcase
        end
    end

    // Pending/display buffers: commit takes the old pending value even when a
    // load lands on the same clock, so the new load simply stays pending.
    always_comb begin
        disp_d     = disp_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        if (commit_c && pend_vld_q) begin
            disp_d     = pend_q;
            pend_vld_d = 1'b0;
        end
        if (i_Load) begin
            pend_d.dp  = i_Dp;
            pend_d.nib = i_Data;
            pend_vld_d = 1'b1;
        end
    end

    // A digit is blanked when it and every digit above it are zero.
    always_comb begin
        lz_blank_c = '0;
        lz_run_c   = i_Lz;
        for (int d = NUM_DIGITS - 1; d > 0; d--) begin
            lz_run_c      = lz_run_c & (disp_q.nib[d] == '0);
            lz_blank_c[d] = lz_run_c;
        end
    end

    seg7_decoder u_dec (
        .nibble_i (disp_q.nib[idx_q]),
        .blank_i  (lz_blank_c[idx_q]),
        .seg_o    (dec_seg_c)
    );

    // Output drive follows the registered state, so anodes lag state by one clock.
    always_comb begin
        anode_d     = '1;
        seg_d       = BLANK_SEG;
        dp_d        = 1'b1;
        frame_arm_d = commit_c;
        frame_d     = frame_arm_q;
        if (state_q == ST_SCAN) begin
            anode_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d   = dec_seg_c;
            dp_d    = ~disp_q.dp[idx_q];
        end
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state_q     <= ST_OFF;
            idx_q       <= '0;
            gcnt_q      <= '0;
            disp_q      <= '0;
            pend_q      <= '0;
            pend_vld_q  <= 1'b0;
            anode_q     <= '1;
            seg_q       <= BLANK_SEG;
            dp_q        <= 1'b1;
            frame_arm_q <= 1'b0;
            frame_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            gcnt_q      <= gcnt_d;
            disp_q      <= disp_d;
            pend_q      <= pend_d;
            pend_vld_q  <= pend_vld_d;
            anode_q     <= anode_d;
            seg_q       <= seg_d;
            dp_q        <= dp_d;
            frame_arm_q <= frame_arm_d;
            frame_q     <= frame_d;
        end
    end

    assign o_Anodo = anode_q;
    assign o_Seg   = seg_q;
    assign o_Dp    = dp_q;
    assign o_Pend  = pend_vld_q;
    assign o_Frame = frame_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: table of loaded values plus hand-written
// commit/reset/enable sequences, digits checked through a scoreboard queue.
module tb_display_scan_ctrl;

    localparam int unsigned GUARD = 4;

    typedef logic [3:0][6:0] segs_t;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic        lz;
        segs_t       seg;
    } vec_t;

    typedef struct packed {
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic       frame;
        logic       gap;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        tick;
    logic        en;
    logic        ld;
    logic [15:0] data;
    logic [3:0]  dp;
    logic        lz;
    logic [3:0]  anodo;
    logic [6:0]  seg;
    logic        o_dp;
    logic        pend;
    logic        frame;

    int n_pass  = 0;
    int n_total = 0;

    exp_t  sb[$];
    segs_t m_dseg, m_pseg;
    logic [3:0] m_ddp, m_pdp;
    logic  m_pvld;
    logic  m_on;
    int    m_idx;

    logic [3:0] prev_an = 4'hF;
    int gap_cnt = 0;

    vec_t vecs[8];

    display_scan_ctrl #(.GUARD_CYC(GUARD)) dut (
        .i_Clk   (clk),
        .i_Reset (rst_n),
        .i_Tick  (tick),
        .i_En    (en),
        .i_Load  (ld),
        .i_Data  (data),
        .i_Dp    (dp),
        .i_Lz    (lz),
        .o_Anodo (anodo),
        .o_Seg   (seg),
        .o_Dp    (o_dp),
        .o_Pend  (pend),
        .o_Frame (frame)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_load(input logic [3:0] d_dp, input segs_t s);
        m_pseg = s;
        m_pdp  = ~d_dp;
        m_pvld = 1'b1;
    endtask

    task automatic model_commit();
        if (m_pvld) begin
            m_dseg = m_pseg;
            m_ddp  = m_pdp;
            m_pvld = 1'b0;
        end
    endtask

    task automatic push(input logic gap);
        exp_t e;
        logic [3:0] one;
        one     = 4'b0001;
        e.anode = ~(one << m_idx);
        e.seg   = m_dseg[m_idx];
        e.dp    = m_ddp[m_idx];
        e.frame = (m_idx == 0);
        e.gap   = gap;
        sb.push_back(e);
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] d_dp, input segs_t s);
        @(posedge clk); #1;
        ld = 1'b1; data = d; dp = d_dp;
        @(posedge clk); #1;
        ld = 1'b0;
        model_load(d_dp, s);
    endtask

    // One scan strobe; a wrap also checks o_Pend around the commit clock and
    // can place a load exactly on that clock.
    task automatic do_tick(input bit extra, input bit lac, input logic [15:0] ld_d,
                           input logic [3:0] ld_dp, input segs_t ld_seg);
        logic gap;
        @(posedge clk); #1 tick = 1'b1;
        @(posedge clk); #1 tick = 1'b0;
        if (m_on && m_idx == 3) begin
            repeat (3) @(posedge clk);
            @(negedge clk);
            chk("pend_before_commit", 32'(pend), 32'(m_pvld));
            if (lac) begin
                ld = 1'b1; data = ld_d; dp = ld_dp;
            end
            @(posedge clk); #1 ld = 1'b0;
            model_commit();
            if (lac) model_load(ld_dp, ld_seg);
            @(negedge clk);
            chk("pend_after_commit", 32'(pend), 32'(m_pvld));
            m_idx = 0;
            push(1'b1);
            repeat (4) @(posedge clk);
        end else begin
            gap = m_on;
            if (!m_on) begin
                m_on  = 1'b1;
                m_idx = 0;
                model_commit();
            end else begin
                m_idx++;
            end
            push(gap);
            if (extra) begin
                @(posedge clk); #1 tick = 1'b1;
                @(posedge clk); #1 tick = 1'b0;
                repeat (6) @(posedge clk);
            end else begin
                repeat (8) @(posedge clk);
            end
        end
    endtask

    // Digit monitor: each new anode-low entry pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (anodo == 4'hF) begin
            gap_cnt++;
            chk("frame_idle", 32'(frame), 32'd0);
        end else if (prev_an == 4'hF) begin
            chk("digit_expected", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("anode", 32'(anodo), 32'(e.anode));
                chk("seg", 32'(seg), 32'(e.seg));
                chk("dp", 32'(o_dp), 32'(e.dp));
                chk("frame", 32'(frame), 32'(e.frame));
                if (e.gap) chk("guard_len", 32'(gap_cnt), 32'(GUARD));
            end
            gap_cnt = 0;
        end else begin
            chk("one_anode", 32'($countones(~anodo)), 32'd1);
            chk("frame_idle", 32'(frame), 32'd0);
        end
        prev_an = anodo;
    end

    initial begin
        vecs[0] = '{16'h1234, 4'b0100, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0007, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
        vecs[2] = '{16'h0007, 4'b0000, 1'b0, {7'h40, 7'h40, 7'h40, 7'h78}};
        vecs[3] = '{16'hABCD, 4'b1001, 1'b1, {7'h08, 7'h03, 7'h46, 7'h21}};
        vecs[4] = '{16'h0506, 4'b1111, 1'b1, {7'h7F, 7'h12, 7'h40, 7'h02}};
        vecs[5] = '{16'h0000, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[6] = '{16'h00F0, 4'b0000, 1'b1, {7'h7F, 7'h7F, 7'h0E, 7'h40}};
        vecs[7] = '{16'hEF89, 4'b0010, 1'b0, {7'h06, 7'h0E, 7'h00, 7'h10}};

        m_dseg = {4{7'h40}};
        m_ddp  = 4'hF;
        m_pseg = {4{7'h40}};
        m_pdp  = 4'hF;
        m_pvld = 1'b0;
        m_on   = 1'b0;
        m_idx  = 0;

        rst_n = 1'b1; tick = 1'b0; en = 1'b0; ld = 1'b0;
        data = '0; dp = '0; lz = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        chk("rst_anode", 32'(anodo), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_dp", 32'(o_dp), 32'd1);
        chk("rst_pend", 32'(pend), 32'd0);
        chk("rst_frame", 32'(frame), 32'd0);
        #9 rst_n = 1'b1;
        en = 1'b1;

        // Table: load each value, then scan one full frame.
        for (int i = 0; i < 8; i++) begin
            lz = vecs[i].lz;
            do_load(vecs[i].data, vecs[i].dp, vecs[i].seg);
            for (int k = 0; k < 4; k++) do_tick(k == 1, 1'b0, '0, '0, '0);
        end

        // Two loads mid-frame: old value held to the wrap, last load wins.
        do_tick(1'b0, 1'b0, '0, '0, '0);
        do_load(16'hAAAA, 4'b0000, {4{7'h08}});
        chk("pend_after_load", 32'(pend), 32'd1);
        do_tick(1'b0, 1'b0, '0, '0, '0);
        do_load(16'h5555, 4'b1111, {4{7'h12}});
        do_tick(1'b0, 1'b0, '0, '0, '0);
        do_tick(1'b0, 1'b0, '0, '0, '0);
        for (int k = 0; k < 4; k++) do_tick(1'b0, 1'b0, '0, '0, '0);

        // Load on the exact commit clock.
        do_load(16'hC0DE, 4'b0001, {7'h46, 7'h40, 7'h21, 7'h06});
        do_tick(1'b0, 1'b1, 16'h9876, 4'b1000, {7'h10, 7'h00, 7'h78, 7'h02});
        chk("pend_held_after_collision", 32'(pend), 32'd1);
        for (int k = 0; k < 3; k++) do_tick(1'b0, 1'b0, '0, '0, '0);
        for (int k = 0; k < 3; k++) do_tick(1'b0, 1'b0, '0, '0, '0);

        // Asynchronous reset while digit 2 is lit, with a load pending.
        do_load(16'h1111, 4'b0000, {4{7'h79}});
        #3 rst_n = 1'b0;
        #1;
        chk("async_rst_anode", 32'(anodo), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_pend", 32'(pend), 32'd0);
        m_on   = 1'b0;
        m_idx  = 0;
        m_dseg = {4{7'h40}};
        m_ddp  = 4'hF;
        m_pvld = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("off_until_tick", 32'(anodo), 32'hF);
        chk("pend_discarded", 32'(pend), 32'd0);
        do_tick(1'b0, 1'b0, '0, '0, '0);
        do_tick(1'b0, 1'b0, '0, '0, '0);

        // Enable low forces off, keeps pending, restarts at digit 0.
        do_load(16'h0123, 4'b0000, {7'h40, 7'h79, 7'h24, 7'h30});
        @(posedge clk); #1 en = 1'b0;
        m_on  = 1'b0;
        m_idx = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("en_low_anode", 32'(anodo), 32'hF);
        chk("en_low_pend_kept", 32'(pend), 32'd1);
        en = 1'b1;
        for (int k = 0; k < 4; k++) do_tick(1'b0, 1'b0, '0, '0, '0);

        repeat (10) @(posedge clk);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
